// File: rtl/mul_sched_pkg.sv
// Shared configuration for the multiplier scheduler: requester count default,
// RISC-V M-extension multiply op encodings and the scheduler state type.
package configure;

  localparam int unsigned DEF_NREQ = 4;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul.sv
// Combinational unsigned XLEN x XLEN multiplier; TYP picks the tree flavour
// (0 Dadda, 1 Wallace). Both flavours compute the identical full product.
module mul #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TYP  = 0
) (
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] c
);

  generate
    if (TYP == 0) begin : g_dadda
      assign c = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    end else begin : g_wallace
      logic [2*XLEN-1:0] acc;
      // Explicit partial-product accumulation; the carry-save reduction is
      // left to synthesis, the sum of rows is what defines the result.
      always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
          if (b[i]) acc = acc + ({{XLEN{1'b0}}, a} << i);
        end
        c = acc;
      end
    end
  endgenerate

endmodule

// File: rtl/mul_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching from ptr upwards, wrapping modulo NREQ.
module mul_rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gidx,
  output logic            any
);

  int unsigned j;

  always_comb begin
    gnt  = '0;
    gidx = '0;
    any  = 1'b0;
    j    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gidx   = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_sched.sv
// Shares one multiplier between NREQ requesters: round-robin accept, sign
// pre/post-processing for MUL/MULH/MULHSU/MULHU, one op per three cycles.
module mul_sched
  import configure::*;
#(
  parameter  int unsigned XLEN = 32,
  parameter  int unsigned TYP  = 0,
  parameter  int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*2-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [XLEN-1:0]      rsp_data
);

  state_t state_q, state_d;

  logic [IW-1:0]     ptr_q;
  logic [XLEN-1:0]   mag_a_q, mag_b_q;
  logic              neg_q, hi_q;
  logic [IW-1:0]     id_q;

  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gidx;
  logic              any;
  logic              accept;

  logic [XLEN-1:0]   a_sel, b_sel;
  logic [1:0]        op_sel;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;

  logic [2*XLEN-1:0] prod, prod_s;

  mul_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (req_valid),
    .ptr  (ptr_q),
    .gnt  (gnt),
    .gidx (gidx),
    .any  (any)
  );

  mul #(.XLEN(XLEN), .TYP(TYP)) u_mul (
    .a (mag_a_q),
    .b (mag_b_q),
    .c (prod)
  );

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = OP_MUL;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx == IW'(i)) begin
        a_sel  = req_a[i*XLEN +: XLEN];
        b_sel  = req_b[i*XLEN +: XLEN];
        op_sel = req_op[i*2 +: 2];
      end
    end
  end

  // The most-negative operand negates to itself, which already is its
  // unsigned magnitude, so no special case is needed.
  always_comb begin
    neg_a = a_sel[XLEN-1] & ((op_sel == OP_MULH) | (op_sel == OP_MULHSU));
    neg_b = b_sel[XLEN-1] & (op_sel == OP_MULH);
    mag_a = neg_a ? -a_sel : a_sel;
    mag_b = neg_b ? -b_sel : b_sel;
  end

  assign prod_s = neg_q ? -prod : prod;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (any && reset) begin
          accept    = 1'b1;
          req_ready = gnt;
          state_d   = CALC;
        end
      end
      CALC: state_d = DONE;
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q     <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      hi_q      <= 1'b0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (accept) begin
        mag_a_q <= mag_a;
        mag_b_q <= mag_b;
        neg_q   <= neg_a ^ neg_b;
        hi_q    <= (op_sel != OP_MUL);
        id_q    <= gidx;
        ptr_q   <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
      end
      if (state_q == CALC) begin
        rsp_data  <= hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end
      if (state_q == DONE && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: directed vectors with literal expectations plus a
// cycle-by-cycle reference model of arbitration, latency and arithmetic.
module tb_mul_sched;

  localparam int SEED = 1;

  logic         clock;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic [7:0]   req_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;

  int checks = 0;
  int errors = 0;

  mul_sched #(.XLEN(32), .TYP(0), .NREQ(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Golden result straight from the ISA definition: widen each operand
  // signed or unsigned, multiply, take the requested half.
  function automatic logic [31:0] golden(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [127:0] ea, eb, pr;
    ea = (op == 2'b01 || op == 2'b10) ? {{96{a[31]}}, a} : {96'b0, a};
    eb = (op == 2'b01) ? {{96{b[31]}}, b} : {96'b0, b};
    pr = ea * eb;
    return (op == 2'b00) ? pr[31:0] : pr[63:32];
  endfunction

  function automatic logic [3:0] rr(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return 4'(1 << ((p + k) % 4));
    end
    return 4'b0;
  endfunction

  // Reference model: an accept is followed by one silent cycle, then the
  // response is presented until consumed; nothing is accepted meanwhile.
  int          mptr = 0;
  bit          busy = 0;
  int          age  = 0;
  int          g;
  int          rsp_count = 0;
  logic [3:0]  er;
  logic [31:0] e_data;
  logic [1:0]  e_id;

  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      busy = 0;
      mptr = 0;
    end else if (!busy) begin
      er = rr(req_valid, mptr);
      chk("idle_req_ready", 64'(req_ready), 64'(er));
      chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
      if (er != 4'b0) begin
        g = 0;
        for (int k = 0; k < 4; k++) if (er[k]) g = k;
        e_id   = 2'(g);
        e_data = golden(req_op[g*2 +: 2], req_a[g*32 +: 32], req_b[g*32 +: 32]);
        mptr   = (g + 1) % 4;
        busy   = 1;
        age    = 0;
      end
    end else begin
      age++;
      chk("busy_req_ready", 64'(req_ready), 64'(0));
      if (age == 1) begin
        chk("calc_rsp_valid", 64'(rsp_valid), 64'(0));
      end else begin
        chk("done_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("done_rsp_id", 64'(rsp_id), 64'(e_id));
        chk("done_rsp_data", 64'(rsp_data), 64'(e_data));
        if (rsp_ready) begin
          busy = 0;
          rsp_count++;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[i*2 +: 2]  = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] d, output logic [1:0] id);
    int n;
    set_req(i, op, a, b);
    req_valid    = 4'b0;
    req_valid[i] = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!req_ready[i] && n < 20);
    if (n >= 20) chk("issue_accept_timeout", 64'(n), 64'(0));
    @(posedge clock); #1;
    req_valid = 4'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!(rsp_valid && rsp_ready) && n < 20);
    if (n >= 20) chk("issue_rsp_timeout", 64'(n), 64'(0));
    d  = rsp_data;
    id = rsp_id;
    @(posedge clock); #1;
  endtask

  logic [31:0] rr_data [5];
  logic [1:0]  rr_ids  [5];
  logic [31:0] d, pick;
  logic [1:0]  id;
  int          n, base;

  function automatic logic [31:0] corner(input int sel);
    case (sel)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rr_data = '{32'hFFFF_FFFE, 32'h0000_0001, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    rr_ids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    void'($urandom(SEED));

    reset     = 1'b0;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    set_req(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_req(1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_req(2, 2'b01, 32'h8000_0000, 32'h8000_0000);
    set_req(3, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b1111;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;

    // Continuous requests from everyone: rotation 0,1,2,3,0.
    for (int r = 0; r < 5; r++) begin
      n = 0;
      do begin @(negedge clock); n++; end while (!rsp_valid && n < 20);
      if (n >= 20) chk("rr_timeout", 64'(n), 64'(0));
      chk("rr_id", 64'(rsp_id), 64'(rr_ids[r]));
      chk("rr_data", 64'(rsp_data), 64'(rr_data[r]));
    end
    @(posedge clock); #1;
    req_valid = 4'b0;

    issue(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, id);
    chk("mulh_m1_data", 64'(d), 64'h0000_0000);
    chk("mulh_m1_id", 64'(id), 64'(0));
    issue(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, id);
    chk("mul_m1_data", 64'(d), 64'h0000_0001);

    // Consumer stall: response frozen, nothing accepted until released.
    rsp_ready = 1'b0;
    set_req(0, 2'b00, 32'd3, 32'd5);
    req_valid = 4'b0001;
    @(posedge clock); #1;
    req_valid = 4'b1111;
    n = 0;
    do begin @(negedge clock); n++; end while (!rsp_valid && n < 20);
    if (n >= 20) chk("stall_timeout", 64'(n), 64'(0));
    for (int k = 0; k < 5; k++) begin
      chk("stall_data", 64'(rsp_data), 64'd15);
      chk("stall_id", 64'(rsp_id), 64'(0));
      chk("stall_req_ready", 64'(req_ready), 64'(0));
      @(negedge clock);
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("stall_resume_grant", 64'(req_ready), 64'b0010);
    @(posedge clock); #1;
    req_valid = 4'b0;
    repeat (4) @(negedge clock);

    // Reset while an op is in flight: dropped, pointer back to 0.
    set_req(2, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    req_valid = 4'b0100;
    n = 0;
    do begin @(negedge clock); n++; end while (!req_ready[2] && n < 20);
    if (n >= 20) chk("rst_accept_timeout", 64'(n), 64'(0));
    @(posedge clock); #1;
    reset     = 1'b0;
    req_valid = 4'b0;
    repeat (2) @(negedge clock);
    chk("rst_drop_valid", 64'(rsp_valid), 64'(0));
    @(posedge clock); #1;
    reset     = 1'b1;
    req_valid = 4'b1100;
    @(negedge clock);
    chk("rst_ptr_grant", 64'(req_ready), 64'b0100);
    @(posedge clock); #1;
    req_valid = 4'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!rsp_valid && n < 20);
    chk("rst_next_data", 64'(rsp_data), 64'(golden(2'b11, 32'h1234_5678, 32'h9ABC_DEF0)));
    chk("rst_next_id", 64'(rsp_id), 64'(2));
    repeat (2) @(negedge clock);

    // Soak: random requesters, ops, corner-heavy operands, stalls.
    base = rsp_count;
    for (int c = 0; c < 600; c++) begin
      @(posedge clock); #1;
      req_valid = 4'($urandom);
      req_op    = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
        pick = corner($urandom_range(0, 9));
        req_a[i*32 +: 32] = pick;
        pick = corner($urandom_range(0, 9));
        req_b[i*32 +: 32] = pick;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clock); #1;
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    repeat (6) @(negedge clock);
    chk("soak_progress", 64'(rsp_count - base > 50), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_sched.md
Name: mul_sched

Overview:
- Shares one combinational `mul` tree (Dadda/Wallace selected by TYP) between NREQ requesters.
- Round-robin arbitration, valid/ready handshakes on request and response channels.
- Signed/unsigned pre- and post-processing selects MUL/MULH/MULHSU/MULHU results.
- Sits between the integer issue units and the multiplier; the only block that instantiates `mul` in the core.

Parameters:
- XLEN, 32, operand width; the product is 2*XLEN.
- TYP, 0, tree type passed to `mul` (0 Dadda, 1 Wallace).
- NREQ, 4, number of requesters (>=2). IW = $clog2(NREQ).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  NREQ*XLEN  operand a; requester i at [i*XLEN +: XLEN]
- req_b  in  NREQ*XLEN  operand b, same packing
- req_op  in  NREQ*2  op for requester i at [i*2 +: 2]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IW  index of requester that owns rsp_data
- rsp_data  out  XLEN  result

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, ptr=0
  - rsp_valid=0, rsp_id=0, rsp_data=0
  - all internal operand/product registers cleared
  - req_ready=0 while reset is asserted
- FSM states IDLE, CALC, DONE.
- IDLE:
  - grant = first i with req_valid[i], searching ptr, ptr+1, … mod NREQ.
  - req_ready[grant]=1 combinationally; all other bits 0. The handshake completes in this cycle.
  - On grant, register:
    - mag_a, mag_b
    - neg = neg_a ^ neg_b
    - hi = (op!=00)
    - id = grant
  - Then set ptr = grant+1 mod NREQ and go to CALC.
  - With no valid requester, stay in IDLE; ptr unchanged.
- CALC:
  - `mul` sees registered mag_a/mag_b.
  - Register rsp_data = hi ? P[2*XLEN-1:XLEN] : P[XLEN-1:0], where P = neg ? -c : c.
  - rsp_id = id, rsp_valid = 1, go to DONE.
- DONE:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1.
  - On rsp_ready=1, rsp_valid drops next cycle and the FSM returns to IDLE.
  - req_ready is 0 in CALC and DONE.
- Latency: accept at cycle t, rsp_valid first high at t+2. Maximum throughput is one operation per 3 cycles.
- Signedness:
  - neg_a = a[XLEN-1] & (op==MULH | op==MULHSU)
  - neg_b = b[XLEN-1] & (op==MULH)
  - mag_x = neg_x ? -x : x (XLEN-bit two's complement).
  - Most-negative operand: -x wraps to the same pattern, which is the correct unsigned magnitude 2^(XLEN-1); no special case.
  - MUL uses an unsigned product; its low half equals the signed low half.
- Fairness: a continuously valid requester is granted within NREQ grants.
- req_valid deasserting without a handshake is permitted; there is no commitment before req_ready.
- Reset mid-operation: the in-flight operation is dropped, no response is produced, ptr returns to 0.
- req_* inputs are sampled only in the accepting IDLE cycle; later changes do not affect the in-flight result.

Decomposition:
- Package `configure` holds:
  - NREQ default
  - op encodings as localparams OP_MUL=2'b00, OP_MULH=2'b01, OP_MULHSU=2'b10, OP_MULHU=2'b11
  - typedef enum of states {IDLE, CALC, DONE}
- Sub-module mul_rr_arbiter (combinational, parameter NREQ):
  - inputs: req vector, ptr
  - outputs: one-hot grant, grant index, any
- mul_sched holds the FSM, ptr, the operand/product registers and the single `mul` instance.

Test Plan:
- Reset held low for 4 cycles with req_valid=4'b1111 -> req_ready=0, rsp_valid=0 throughout; after release the first grant is id 0.
- Req0 MULHU a=FFFFFFFF b=FFFFFFFF -> rsp_data=FFFFFFFE, rsp_id=0, rsp_valid 2 cycles after accept; same operands with MUL -> 00000001.
- MULH a=80000000 b=80000000 -> 40000000; MULH a=FFFFFFFF b=FFFFFFFF -> 00000000; MULHSU a=FFFFFFFF b=FFFFFFFF -> FFFFFFFF.
- All four requesters valid continuously -> grant order 0,1,2,3,0; each id appears exactly once per 4 responses.
- rsp_ready held 0 for 5 cycles in DONE -> rsp_data/rsp_id stable, req_ready=0, no new accept; accept resumes the cycle after the rsp_ready handshake.
- Reset pulsed in CALC -> no response emitted, ptr=0, next grant follows the reset priority.
- Random soak with SEED, all ops and requesters: each response equals the golden (a*b) slice selected by op and signedness.
